header_stripper: RTL and testbench

//  Removes a fixed-size header from the front of each Avalon-ST packet and presents it as a parallel word.

---
 rtl/header_stripper_pkg.sv | 26 ++
 rtl/avalon_st_if.sv | 22 ++
 rtl/header_capture.sv | 113 +++++++++++
 rtl/header_stripper.sv | 161 ++++++++++++++++
 tb/tb_header_stripper.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/header_stripper_pkg.sv
// -----------------------------------------------------------------------------
// header_stripper_pkg
//   Shared types and elaboration helpers for the header stripper slice.
//   - state_e            : control FSM states (DROP_ST only reachable when the
//                          HEADER_STRIPPER_FILTER_EN build option is defined)
//   - header_word_count  : number of stream words making up one header
//   - empty_width        : width of the Avalon-ST empty field for a data width
// -----------------------------------------------------------------------------
package header_stripper_pkg;

    typedef enum logic [1:0] {
        HDR_ST  = 2'd0,
        DATA_ST = 2'd1,
        DROP_ST = 2'd2
    } state_e;

    function automatic int header_word_count(input int header_size, input int data_width);
        return header_size / data_width;
    endfunction

    // Byte-lane count needs at least one bit even for an 8-bit bus.
    function automatic int empty_width(input int data_width);
        return (data_width > 8) ? $clog2(data_width / 8) : 1;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// -----------------------------------------------------------------------------
// avalon_st_if
//   Avalon-ST packet interface: data, valid, ready, sop, eop, empty.
//   modport master : source side (drives data/valid/sop/eop/empty, reads ready)
//   modport slave  : sink side   (reads data/valid/sop/eop/empty, drives ready)
// -----------------------------------------------------------------------------
interface avalon_st_if
    import header_stripper_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int EMPTY_WIDTH = empty_width(DATA_WIDTH)
);
    logic [DATA_WIDTH-1:0]  data;
    logic                   valid;
    logic                   ready;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;

    modport master (output data, valid, sop, eop, empty, input ready);
    modport slave  (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/header_capture.sv
// -----------------------------------------------------------------------------
// header_capture
//   Word-indexed header capture. Each accepted header-phase word is stored in
//   slot cnt (slot 0 on sop); the word completing the header is merged with the
//   stored slots and loaded into header_data in one step, so partial captures
//   never disturb the last complete header.
//   Build option HEADER_STRIPPER_FILTER_EN adds the match/mask compare on the
//   completed header.
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   wr_en         : a word is accepted while the stripper is in its header phase
//   wr_sop/wr_eop : sop/eop of that word
//   wr_data       : the word itself
//   hdr_match     : (filter build) expected header value
//   hdr_mask      : (filter build) bits of hdr_match that are compared
//   mismatch      : (filter build) completed header differs under mask (valid with load)
//   load          : combinational strobe, this word completes a header
//   header_data   : last complete header, MSBs = first stream word
//   done          : 1-cycle pulse, header_data just updated
//   err           : 1-cycle pulse, truncated header or sop resync
// -----------------------------------------------------------------------------
module header_capture
    import header_stripper_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int HEADER_SIZE = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic                   wr_sop,
    input  logic                   wr_eop,
    input  logic [DATA_WIDTH-1:0]  wr_data,
`ifdef HEADER_STRIPPER_FILTER_EN
    input  logic [HEADER_SIZE-1:0] hdr_match,
    input  logic [HEADER_SIZE-1:0] hdr_mask,
    output logic                   mismatch,
`endif
    output logic                   load,
    output logic [HEADER_SIZE-1:0] header_data,
    output logic                   done,
    output logic                   err
);

    localparam int HWC = header_word_count(HEADER_SIZE, DATA_WIDTH);
    localparam int CW  = $clog2(HWC) + 1;

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          slot;
    logic                   take;
    logic [HEADER_SIZE-1:0] buf_q, buf_d;
    logic [HEADER_SIZE-1:0] assembled;
    logic [HEADER_SIZE-1:0] header_q, header_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        // Out-of-packet words (no sop while idle) are not captured.
        take = wr_en && (wr_sop || (cnt_q != '0));
        // A sop always restarts the capture at slot 0.
        slot = wr_sop ? '0 : cnt_q;
        load = take && !wr_eop && (slot == CW'(HWC - 1));

        for (int i = 0; i < HWC; i++) begin
            assembled[HEADER_SIZE-1-i*DATA_WIDTH -: DATA_WIDTH] =
                (slot == CW'(i)) ? wr_data : buf_q[HEADER_SIZE-1-i*DATA_WIDTH -: DATA_WIDTH];
        end

        buf_d = take ? assembled : buf_q;

        cnt_d = cnt_q;
        if (take) begin
            cnt_d = (wr_eop || load) ? '0 : slot + CW'(1);
        end

        header_d = load ? assembled : header_q;
        done_d   = load;
        err_d    = wr_en && ((wr_sop && (cnt_q != '0)) || (take && wr_eop));
    end

`ifdef HEADER_STRIPPER_FILTER_EN
    assign mismatch = |((assembled ^ hdr_match) & hdr_mask);
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            header_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            header_q <= header_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // NOTE: the slot buffer has no reset; every slot is written by the current
    // packet before it can reach header_data.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign header_data = header_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: rtl/header_stripper.sv
// -----------------------------------------------------------------------------
// header_stripper
//   Strips a fixed HEADER_SIZE-bit header from the front of each Avalon-ST
//   packet, presents it as a parallel word and forwards the payload as a new
//   packet with sop re-marked on the first payload word. The payload path is a
//   zero-latency combinational pass-through.
//   Build option HEADER_STRIPPER_FILTER_EN: packets whose header mismatches
//   header_match under header_mask are absorbed without output (pkt_drop).
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   data_in      : avalon_st_if.slave, incoming packets
//   data_out     : avalon_st_if.master, payload packets
//   header_match : (filter build) expected header value
//   header_mask  : (filter build) compared bits
//   pkt_drop     : (filter build) 1-cycle pulse with header_vld on a drop
//   header_data  : captured header, first stream word in the MSBs
//   header_vld   : 1-cycle pulse, header_data complete and valid
//   hdr_err      : 1-cycle pulse, truncated header or sop resync
// -----------------------------------------------------------------------------
module header_stripper
    import header_stripper_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int HEADER_SIZE = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    avalon_st_if.slave             data_in,
    avalon_st_if.master            data_out,
`ifdef HEADER_STRIPPER_FILTER_EN
    input  logic [HEADER_SIZE-1:0] header_match,
    input  logic [HEADER_SIZE-1:0] header_mask,
    output logic                   pkt_drop,
`endif
    output logic [HEADER_SIZE-1:0] header_data,
    output logic                   header_vld,
    output logic                   hdr_err
);

    if ((HEADER_SIZE < DATA_WIDTH) || ((HEADER_SIZE % DATA_WIDTH) != 0)) begin : g_bad_cfg
        $error("header_stripper: HEADER_SIZE must be a non-zero multiple of DATA_WIDTH");
    end

    state_e state_q, state_d;
    logic   first_q, first_d;
    logic   hdr_wr_en;
    logic   hdr_load;
    logic   in_ready;
    logic   out_valid;
    logic   out_sop;
    logic   out_eop;

    assign hdr_wr_en = (state_q == HDR_ST) && data_in.valid;

`ifdef HEADER_STRIPPER_FILTER_EN
    logic hdr_mismatch;
    logic drop_q;
`endif

    header_capture #(
        .DATA_WIDTH  (DATA_WIDTH),
        .HEADER_SIZE (HEADER_SIZE)
    ) u_capture (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (hdr_wr_en),
        .wr_sop      (data_in.sop),
        .wr_eop      (data_in.eop),
        .wr_data     (data_in.data),
`ifdef HEADER_STRIPPER_FILTER_EN
        .hdr_match   (header_match),
        .hdr_mask    (header_mask),
        .mismatch    (hdr_mismatch),
`endif
        .load        (hdr_load),
        .header_data (header_data),
        .done        (header_vld),
        .err         (hdr_err)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HDR_ST;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

`ifdef HEADER_STRIPPER_FILTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= hdr_load && hdr_mismatch;
        end
    end

    assign pkt_drop = drop_q;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        unique case (state_q)
            HDR_ST: begin
                if (hdr_load) begin
                    state_d = DATA_ST;
                    first_d = 1'b1;
`ifdef HEADER_STRIPPER_FILTER_EN
                    if (hdr_mismatch) begin
                        state_d = DROP_ST;
                        first_d = 1'b0;
                    end
`endif
                end
            end
            DATA_ST: begin
                if (data_in.valid && data_out.ready) begin
                    first_d = 1'b0;
                    if (data_in.eop) begin
                        state_d = HDR_ST;
                    end
                end
            end
            DROP_ST: begin
                // Always ready here, so valid alone is a handshake.
                if (data_in.valid && data_in.eop) begin
                    state_d = HDR_ST;
                end
            end
            default: state_d = HDR_ST;
        endcase
    end

    // Output logic: header and drop phases absorb words, data phase passes through.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        if (state_q == DATA_ST) begin
            in_ready  = data_out.ready;
            out_valid = data_in.valid;
            // Input sop is payload here; only the first payload word is marked.
            out_sop   = data_in.valid && first_q;
            out_eop   = data_in.valid && data_in.eop;
        end
    end

    assign data_in.ready  = in_ready;
    assign data_out.valid = out_valid;
    assign data_out.sop   = out_sop;
    assign data_out.eop   = out_eop;
    assign data_out.data  = data_in.data;
    assign data_out.empty = out_eop ? data_in.empty : '0;

endmodule

// File: tb/tb_header_stripper.sv
module tb_header_stripper;

    localparam int DW = 32;
    localparam int HS = 64;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    logic clk;
    logic rst_n;

    avalon_st_if #(.DATA_WIDTH(DW)) in_if ();
    avalon_st_if #(.DATA_WIDTH(DW)) out_if ();

    logic [HS-1:0] header_data;
    logic          header_vld;
    logic          hdr_err;
`ifdef HEADER_STRIPPER_FILTER_EN
    logic [HS-1:0] header_match;
    logic [HS-1:0] header_mask;
    logic          pkt_drop;
`endif

    header_stripper #(
        .DATA_WIDTH  (DW),
        .HEADER_SIZE (HS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (in_if),
        .data_out     (out_if),
`ifdef HEADER_STRIPPER_FILTER_EN
        .header_match (header_match),
        .header_mask  (header_mask),
        .pkt_drop     (pkt_drop),
`endif
        .header_data  (header_data),
        .header_vld   (header_vld),
        .hdr_err      (hdr_err)
    );

    beat_t         exp_q[$];
    logic [HS-1:0] hdr_q[$];
    int            err_seen;
    int            drop_seen;
    int            checks;
    int            failures;
    bit            tgl_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, got time=%0t required < 500000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Sink ready: constant 1, or toggling every cycle when tgl_en is set.
    initial begin
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.ready = tgl_en ? ~out_if.ready : 1'b1;
        end
    end

    // Monitor: compares at negedge, ahead of the edge where the handshake lands.
    initial begin
        beat_t got_b;
        beat_t exp_b;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_if.valid && out_if.ready) begin
                    got_b = '{out_if.data, out_if.sop, out_if.eop, out_if.empty};
                    if (exp_q.size() == 0) begin
                        check("out_unexpected_beats_pending", 64'(exp_q.size()), 64'd1);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("out_beat", 64'(got_b), 64'(exp_b));
                    end
                end
                if (header_vld) begin
                    if (hdr_q.size() == 0) begin
                        check("header_vld_unexpected_pending", 64'(hdr_q.size()), 64'd1);
                    end else begin
                        check("header_data", header_data, hdr_q.pop_front());
                    end
                end
                if (hdr_err) err_seen++;
`ifdef HEADER_STRIPPER_FILTER_EN
                if (pkt_drop) drop_seen++;
`endif
            end
        end
    end

    task automatic exp_beat(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em);
        beat_t b;
        b.data  = d;
        b.sop   = s;
        b.eop   = e;
        b.empty = em;
        exp_q.push_back(b);
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em);
        int cyc;
        bit hs;
        in_if.data  = d;
        in_if.sop   = s;
        in_if.eop   = e;
        in_if.empty = em;
        in_if.valid = 1'b1;
        cyc = 0;
        hs  = 1'b0;
        while (!hs && cyc < 50) begin
            @(negedge clk);
            hs = in_if.ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!hs) check("in_ready_timeout", 64'(hs), 64'd1);
        in_if.valid = 1'b0;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
    endtask

    task automatic finish_test(input string name, input int exp_err, input int exp_drop);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_beats_missing"}, 64'(exp_q.size()), 64'd0);
        check({name, "_headers_missing"}, 64'(hdr_q.size()), 64'd0);
        check({name, "_hdr_err_count"}, 64'(err_seen), 64'(exp_err));
`ifdef HEADER_STRIPPER_FILTER_EN
        check({name, "_pkt_drop_count"}, 64'(drop_seen), 64'(exp_drop));
`else
        if (exp_drop != 0) check({name, "_pkt_drop_count"}, 64'(drop_seen), 64'(exp_drop));
`endif
        exp_q.delete();
        hdr_q.delete();
        err_seen  = 0;
        drop_seen = 0;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_out_valid"}, 64'(out_if.valid), 64'd0);
        check({name, "_out_sop"}, 64'(out_if.sop), 64'd0);
        check({name, "_out_eop"}, 64'(out_if.eop), 64'd0);
        check({name, "_out_empty"}, 64'(out_if.empty), 64'd0);
        check({name, "_header_vld"}, 64'(header_vld), 64'd0);
        check({name, "_hdr_err"}, 64'(hdr_err), 64'd0);
        check({name, "_header_data"}, header_data, 64'd0);
        check({name, "_in_ready"}, 64'(in_if.ready), 64'd1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        err_seen    = 0;
        drop_seen   = 0;
        tgl_en      = 1'b0;
        rst_n       = 1'b0;
        in_if.valid = 1'b0;
        in_if.data  = '0;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
        in_if.empty = '0;
`ifdef HEADER_STRIPPER_FILTER_EN
        header_match = '0;
        header_mask  = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: basic strip, sink always ready
        hdr_q.push_back(64'hA1B2C3D4_11223344);
        exp_beat(32'hDEAD0001, 1'b1, 1'b0, 2'd0);
        exp_beat(32'hDEAD0002, 1'b0, 1'b1, 2'd2);
        send(32'hA1B2C3D4, 1'b1, 1'b0, 2'd0);
        send(32'h11223344, 1'b0, 1'b0, 2'd0);
        send(32'hDEAD0001, 1'b0, 1'b0, 2'd0);
        send(32'hDEAD0002, 1'b0, 1'b1, 2'd2);
        finish_test("t1", 0, 0);

        // 2: same packet with sink ready toggling
        tgl_en = 1'b1;
        hdr_q.push_back(64'hA1B2C3D4_11223344);
        exp_beat(32'hDEAD0001, 1'b1, 1'b0, 2'd0);
        exp_beat(32'hDEAD0002, 1'b0, 1'b1, 2'd2);
        send(32'hA1B2C3D4, 1'b1, 1'b0, 2'd0);
        send(32'h11223344, 1'b0, 1'b0, 2'd0);
        send(32'hDEAD0001, 1'b0, 1'b0, 2'd0);
        send(32'hDEAD0002, 1'b0, 1'b1, 2'd2);
        finish_test("t2", 0, 0);
        tgl_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 3: truncated header (eop on header word), then a good packet
        send(32'h11110000, 1'b1, 1'b0, 2'd0);
        send(32'h22220000, 1'b0, 1'b1, 2'd0);
        hdr_q.push_back(64'hCAFEBABE_00000005);
        exp_beat(32'h77777777, 1'b1, 1'b1, 2'd1);
        send(32'hCAFEBABE, 1'b1, 1'b0, 2'd0);
        send(32'h00000005, 1'b0, 1'b0, 2'd0);
        send(32'h77777777, 1'b0, 1'b1, 2'd1);
        finish_test("t3", 1, 0);

        // 4: sop resync inside the header
        hdr_q.push_back(64'h12345678_9ABCDEF0);
        exp_beat(32'h00000001, 1'b1, 1'b1, 2'd0);
        send(32'hAAAA0000, 1'b1, 1'b0, 2'd0);
        send(32'h12345678, 1'b1, 1'b0, 2'd0);
        send(32'h9ABCDEF0, 1'b0, 1'b0, 2'd0);
        send(32'h00000001, 1'b0, 1'b1, 2'd0);
        finish_test("t4", 1, 0);

        // 5: idle-gap words, then reset in the middle of the payload
        send(32'h55550000, 1'b0, 1'b0, 2'd0);
        send(32'h55550001, 1'b0, 1'b1, 2'd0);
        hdr_q.push_back(64'h01020304_05060708);
        exp_beat(32'h0000AAA1, 1'b1, 1'b0, 2'd0);
        send(32'h01020304, 1'b1, 1'b0, 2'd0);
        send(32'h05060708, 1'b0, 1'b0, 2'd0);
        send(32'h0000AAA1, 1'b0, 1'b0, 2'd0);
        check("t5_beats_before_reset", 64'(exp_q.size()), 64'd0);
        check("t5_headers_before_reset", 64'(hdr_q.size()), 64'd0);
        in_if.data  = 32'h0000AAA2;
        in_if.valid = 1'b1;
        rst_n       = 1'b0;
        @(negedge clk);
        check_idle_outputs("t5_in_reset");
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        rst_n       = 1'b1;
        err_seen    = 0;
        @(posedge clk);
        #1;
        send(32'h0000AAA2, 1'b0, 1'b0, 2'd0);
        send(32'h0000AAA3, 1'b0, 1'b1, 2'd0);
        hdr_q.push_back(64'h10101010_20202020);
        exp_beat(32'h30303030, 1'b1, 1'b0, 2'd0);
        exp_beat(32'h40404040, 1'b0, 1'b1, 2'd3);
        send(32'h10101010, 1'b1, 1'b0, 2'd0);
        send(32'h20202020, 1'b0, 1'b0, 2'd0);
        send(32'h30303030, 1'b0, 1'b0, 2'd0);
        send(32'h40404040, 1'b0, 1'b1, 2'd3);
        finish_test("t5", 0, 0);

`ifdef HEADER_STRIPPER_FILTER_EN
        // 6: header filter, pass then drop then pass
        header_mask  = 64'hFFFFFFFF_00000000;
        header_match = 64'hA1B2C3D4_00000000;
        hdr_q.push_back(64'hA1B2C3D4_55555555);
        exp_beat(32'hCAFE0001, 1'b1, 1'b1, 2'd0);
        send(32'hA1B2C3D4, 1'b1, 1'b0, 2'd0);
        send(32'h55555555, 1'b0, 1'b0, 2'd0);
        send(32'hCAFE0001, 1'b0, 1'b1, 2'd0);
        hdr_q.push_back(64'h0BADBEEF_66666666);
        send(32'h0BADBEEF, 1'b1, 1'b0, 2'd0);
        send(32'h66666666, 1'b0, 1'b0, 2'd0);
        send(32'h00000001, 1'b0, 1'b0, 2'd0);
        send(32'h00000002, 1'b0, 1'b0, 2'd0);
        send(32'h00000003, 1'b0, 1'b1, 2'd0);
        hdr_q.push_back(64'hA1B2C3D4_00000009);
        exp_beat(32'hCAFE0002, 1'b1, 1'b1, 2'd0);
        send(32'hA1B2C3D4, 1'b1, 1'b0, 2'd0);
        send(32'h00000009, 1'b0, 1'b0, 2'd0);
        send(32'hCAFE0002, 1'b0, 1'b1, 2'd0);
        finish_test("t6", 0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
